drain_collector: RTL and testbench

- Output-side counterpart of the systolic array's input skewer.
- The input skewer feeds a 4x4 operand matrix into 4 lanes as a diagonal wavefront over 7 beats.
- This block takes a 4-lane diagonally skewed wavefront coming out of the array, de-skews it, and reassembles a 4x4 result matrix.
- It signals completion with a one-cycle done pulse and holds the matrix stable for the downstream consumer.

---
 rtl/drain_collector.sv | 135 +++++++++++++
 tb/tb_drain_collector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/drain_collector.sv
// drain_collector: de-skews a 4-lane diagonal wavefront from the systolic array
// and reassembles it into a 4x4 result matrix held stable for the consumer.
module drain_collector #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q_valid,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  input  logic [WIDTH-1:0] q4,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [WIDTH-1:0] o11,
  output logic [WIDTH-1:0] o12,
  output logic [WIDTH-1:0] o13,
  output logic [WIDTH-1:0] o14,
  output logic [WIDTH-1:0] o21,
  output logic [WIDTH-1:0] o22,
  output logic [WIDTH-1:0] o23,
  output logic [WIDTH-1:0] o24,
  output logic [WIDTH-1:0] o31,
  output logic [WIDTH-1:0] o32,
  output logic [WIDTH-1:0] o33,
  output logic [WIDTH-1:0] o34,
  output logic [WIDTH-1:0] o41,
  output logic [WIDTH-1:0] o42,
  output logic [WIDTH-1:0] o43,
  output logic [WIDTH-1:0] o44
);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e           state_q;
  logic [2:0]       beat_q;
  logic             busy_q;
  logic             done_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] mat_q [4][4];

  logic [WIDTH-1:0] lane   [4];
  logic             wr_en  [4];
  logic [1:0]       wr_row [4];
  logic [3:0]       next_beat;

  assign lane[0] = q1;
  assign lane[1] = q2;
  assign lane[2] = q3;
  assign lane[3] = q4;

  // Decode which lanes are live for the upcoming beat and which row each one lands in.
  always_comb begin
    next_beat = {1'b0, beat_q} + 4'd1;
    for (int jj = 0; jj < 4; jj++) begin
      wr_en[jj]  = 1'b0;
      wr_row[jj] = 2'd0;
      // Lane jj+1 is active on beats jj+1 .. jj+4 and fills rows bottom-up.
      if ((4'(jj + 1) <= next_beat) && (next_beat <= 4'(jj + 4))) begin
        wr_en[jj]  = 1'b1;
        wr_row[jj] = 2'(jj + 4 - int'(next_beat));
      end
    end
  end

  // Collection FSM with registered status outputs and the matrix store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beat_q      <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // q_valid is ignored here, including in the start cycle.
          if (start) begin
            state_q     <= StCollect;
            beat_q      <= 3'd0;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        StCollect: begin
          if (q_valid) begin
            beat_q <= beat_q + 3'd1;
            for (int jj = 0; jj < 4; jj++) begin
              if (wr_en[jj]) begin
                mat_q[wr_row[jj]][jj] <= lane[jj];
              end
            end
            if (beat_q == 3'd6) begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              out_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;

  assign o11 = mat_q[0][0];
  assign o12 = mat_q[0][1];
  assign o13 = mat_q[0][2];
  assign o14 = mat_q[0][3];
  assign o21 = mat_q[1][0];
  assign o22 = mat_q[1][1];
  assign o23 = mat_q[1][2];
  assign o24 = mat_q[1][3];
  assign o31 = mat_q[2][0];
  assign o32 = mat_q[2][1];
  assign o33 = mat_q[2][2];
  assign o34 = mat_q[2][3];
  assign o41 = mat_q[3][0];
  assign o42 = mat_q[3][1];
  assign o43 = mat_q[3][2];
  assign o44 = mat_q[3][3];

endmodule

// File: tb/tb_drain_collector.sv
// Self-checking bench for drain_collector: directed scenarios plus randomized
// collections, checked against a matrix-level reference model.
module tb_drain_collector;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         q_valid = 1'b0;
  logic [W-1:0] q1 = '0, q2 = '0, q3 = '0, q4 = '0;
  logic         busy, done, out_valid;
  logic [W-1:0] o11, o12, o13, o14, o21, o22, o23, o24;
  logic [W-1:0] o31, o32, o33, o34, o41, o42, o43, o44;

  logic [W-1:0] got     [4][4];
  logic [W-1:0] exp_mat [4][4];
  logic [W-1:0] m       [4][4];
  logic         exp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  drain_collector #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q_valid(q_valid),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .busy(busy), .done(done), .out_valid(out_valid),
    .o11(o11), .o12(o12), .o13(o13), .o14(o14),
    .o21(o21), .o22(o22), .o23(o23), .o24(o24),
    .o31(o31), .o32(o32), .o33(o33), .o34(o34),
    .o41(o41), .o42(o42), .o43(o43), .o44(o44)
  );

  assign got[0][0] = o11; assign got[0][1] = o12; assign got[0][2] = o13; assign got[0][3] = o14;
  assign got[1][0] = o21; assign got[1][1] = o22; assign got[1][2] = o23; assign got[1][3] = o24;
  assign got[2][0] = o31; assign got[2][1] = o32; assign got[2][2] = o33; assign got[2][3] = o34;
  assign got[3][0] = o41; assign got[3][1] = o42; assign got[3][2] = o43; assign got[3][3] = o44;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got_v, input logic [W-1:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic check_ctl(input string tag, input logic b, input logic d, input logic v);
    check({tag, " busy"}, W'(busy), W'(b));
    check({tag, " done"}, W'(done), W'(d));
    check({tag, " out_valid"}, W'(out_valid), W'(v));
  endtask

  task automatic check_mat(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("%s o%0d%0d", tag, r + 1, c + 1), got[r][c], exp_mat[r][c]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes_all(input logic [W-1:0] v);
    q1 = v; q2 = v; q3 = v; q4 = v;
  endtask

  // Lane j at beat b carries element (row j+4-b, col j) when j <= b <= j+3.
  function automatic logic [W-1:0] lane_val(input int j, input int b);
    if (j <= b && b <= j + 3) return m[j + 3 - b][j - 1];
    return 32'hDEAD;
  endfunction

  // One full collection. data_mode 0: base + 0x10*r + c, else random.
  // stall_mode 0: none, 1: 3 before beat 3 and 1 before beat 6, 2: random.
  task automatic collect(input int data_mode, input logic [W-1:0] base, input int stall_mode,
                         input bit start_mid, input bit same_qv, input int abort_at);
    int nst;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = (data_mode == 0) ? base + W'(16 * (r + 1) + (c + 1)) : W'($urandom);
    start = 1'b1;
    q_valid = same_qv;
    set_lanes_all(same_qv ? 32'h99 : 32'hDEAD);
    tick();
    start = 1'b0;
    q_valid = 1'b0;
    exp_valid = 1'b0;
    check_ctl("start", 1'b1, 1'b0, 1'b0);
    for (int b = 1; b <= 7; b++) begin
      if (stall_mode == 1) nst = (b == 3) ? 3 : ((b == 6) ? 1 : 0);
      else if (stall_mode == 2) nst = int'($urandom_range(0, 2));
      else nst = 0;
      repeat (nst) begin
        q_valid = 1'b0;
        set_lanes_all(32'hFFFF);
        tick();
        check_ctl("stall", 1'b1, 1'b0, 1'b0);
      end
      q_valid = 1'b1;
      q1 = lane_val(1, b);
      q2 = lane_val(2, b);
      q3 = lane_val(3, b);
      q4 = lane_val(4, b);
      start = start_mid && (b == 3);
      tick();
      q_valid = 1'b0;
      start = 1'b0;
      if (b == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            exp_mat[r][c] = '0;
        exp_valid = 1'b0;
        check_ctl("async rst", 1'b0, 1'b0, 1'b0);
        check_mat("async rst");
        #2 rst_n = 1'b1;
        tick();
        return;
      end
      if (b < 7) begin
        check_ctl("beat", 1'b1, 1'b0, 1'b0);
      end else begin
        exp_mat = m;
        exp_valid = 1'b1;
        check_ctl("done", 1'b0, 1'b1, 1'b1);
        check_mat("final");
      end
    end
  endtask

  task automatic idle_check(input string tag);
    tick();
    check_ctl(tag, 1'b0, 1'b0, exp_valid);
    check_mat(tag);
  endtask

  initial begin
    exp_valid = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_mat[r][c] = '0;

    #12;
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_mat("reset");
    rst_n = 1'b1;
    tick();

    // Basic de-skew, then done must drop.
    collect(0, '0, 0, 1'b0, 1'b0, 0);
    idle_check("after done");

    // Directed stalls with junk on the lanes.
    collect(0, '0, 1, 1'b0, 1'b0, 0);
    idle_check("after stall");

    // q_valid in idle is ignored; start at beat 3 is ignored.
    repeat (3) begin
      q_valid = 1'b1;
      set_lanes_all(W'($urandom));
      idle_check("idle qv");
    end
    q_valid = 1'b0;
    collect(0, '0, 0, 1'b1, 1'b0, 0);

    // Back-to-back: restart in the done cycle.
    collect(0, 32'h100, 0, 1'b0, 1'b0, 0);
    check("b2b o34", o34, 32'h134);
    idle_check("after b2b");

    // Async reset after beat 4, then a clean collection.
    collect(1, '0, 0, 1'b0, 1'b0, 4);
    idle_check("post reset idle");
    collect(0, '0, 0, 1'b0, 1'b0, 0);

    // Start with q_valid in the same cycle.
    collect(0, '0, 0, 1'b0, 1'b1, 0);
    idle_check("after same qv");

    // Randomized collections.
    repeat (20) begin
      collect(1, '0, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) begin
        q_valid = 1'($urandom_range(0, 1));
        set_lanes_all(W'($urandom));
        idle_check("rand idle");
        q_valid = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
